// File: rtl/video_timing_out.sv
`default_nettype none
// ============================================================================
// video_timing_out : raster counters, delay-matched de/sync/color outputs
// Rev 1.0
// ============================================================================
module video_timing_out #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned COLOR_DELAY = 9,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] count_h,
  output logic [31:0] count_v,
  input  logic [7:0]  color_in,
  output logic [7:0]  vga_color,
  output logic        vga_de,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vblank,
  output logic        frame_start,
  output logic [31:0] frame_count
);

  localparam int unsigned c_H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned c_V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned c_HS_START  = H_VISIBLE + H_FRONT;
  localparam int unsigned c_HS_END    = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned c_VS_START  = V_VISIBLE + V_FRONT;
  localparam int unsigned c_VS_END    = V_VISIBLE + V_FRONT + V_SYNC;

  logic [31:0]            r_count_h;
  logic [31:0]            r_count_v;
  logic                   w_line_end;
  logic                   w_de;
  logic                   w_hs;
  logic                   w_vs;
  logic                   w_frame_edge;
  logic [COLOR_DELAY-1:0] r_de_pipe;
  logic [COLOR_DELAY-1:0] r_hs_pipe;
  logic [COLOR_DELAY-1:0] r_vs_pipe;
  logic                   w_de_d;
  logic                   w_hs_d;
  logic                   w_vs_d;
  logic [7:0]             r_vga_color;
  logic                   r_vga_de;
  logic                   r_vga_hs;
  logic                   r_vga_vs;
  logic                   r_frame_start;
  logic [31:0]            r_frame_count;

  assign w_line_end = (r_count_h == c_H_TOTAL - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count_h <= '0;
      r_count_v <= '0;
    end else if (w_line_end) begin
      r_count_h <= '0;
      if (r_count_v == c_V_TOTAL - 1) begin
        r_count_v <= '0;
      end else begin
        r_count_v <= r_count_v + 32'd1;
      end
    end else begin
      r_count_h <= r_count_h + 32'd1;
    end
  end

  // Raw timing decoded straight from the counters; vsync uses count_v only
  assign w_de = (r_count_h < H_VISIBLE) && (r_count_v < V_VISIBLE);
  assign w_hs = (r_count_h >= c_HS_START) && (r_count_h < c_HS_END);
  assign w_vs = (r_count_v >= c_VS_START) && (r_count_v < c_VS_END);

  generate
    if (COLOR_DELAY > 1) begin : g_pipe_multi
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_de_pipe <= '0;
          r_hs_pipe <= '0;
          r_vs_pipe <= '0;
        end else begin
          r_de_pipe <= {r_de_pipe[COLOR_DELAY-2:0], w_de};
          r_hs_pipe <= {r_hs_pipe[COLOR_DELAY-2:0], w_hs};
          r_vs_pipe <= {r_vs_pipe[COLOR_DELAY-2:0], w_vs};
        end
      end
    end else begin : g_pipe_single
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_de_pipe <= '0;
          r_hs_pipe <= '0;
          r_vs_pipe <= '0;
        end else begin
          r_de_pipe <= w_de;
          r_hs_pipe <= w_hs;
          r_vs_pipe <= w_vs;
        end
      end
    end
  endgenerate

  assign w_de_d = r_de_pipe[COLOR_DELAY-1];
  assign w_hs_d = r_hs_pipe[COLOR_DELAY-1];
  assign w_vs_d = r_vs_pipe[COLOR_DELAY-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vga_color <= 8'h00;
      r_vga_de    <= 1'b0;
      r_vga_hs    <= ~SYNC_ACTIVE;
      r_vga_vs    <= ~SYNC_ACTIVE;
    end else begin
      r_vga_color <= w_de_d ? color_in : 8'h00;
      r_vga_de    <= w_de_d;
      r_vga_hs    <= w_hs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vga_vs    <= w_vs_d ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  // First pixel clock of vertical blank marks a completed visible frame
  assign w_frame_edge = (r_count_h == 32'd0) && (r_count_v == V_VISIBLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_start <= w_frame_edge;
      if (w_frame_edge) begin
        r_frame_count <= r_frame_count + 32'd1;
      end
    end
  end

  assign count_h     = r_count_h;
  assign count_v     = r_count_v;
  assign vblank      = (r_count_v >= V_VISIBLE);
  assign vga_color   = r_vga_color;
  assign vga_de      = r_vga_de;
  assign vga_hs      = r_vga_hs;
  assign vga_vs      = r_vga_vs;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_out.sv
`default_nettype none
// ============================================================================
// tb_video_timing_out : default-size line checks plus small-raster frame model
// Rev 1.0
// ============================================================================
module tb_video_timing_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  col_d, col_s;

  logic [31:0] d_ch, d_cv, d_fc, s_ch, s_cv, s_fc;
  logic [7:0]  d_col, s_col;
  logic        d_de, d_hs, d_vs, d_vb, d_fs;
  logic        s_de, s_hs, s_vs, s_vb, s_fs;

  video_timing_out u_dut (
    .clk(clk), .reset(rst_n), .count_h(d_ch), .count_v(d_cv), .color_in(col_d),
    .vga_color(d_col), .vga_de(d_de), .vga_hs(d_hs), .vga_vs(d_vs),
    .vblank(d_vb), .frame_start(d_fs), .frame_count(d_fc)
  );

  video_timing_out #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .COLOR_DELAY(3), .SYNC_ACTIVE(1'b1)
  ) u_small (
    .clk(clk), .reset(rst_n), .count_h(s_ch), .count_v(s_cv), .color_in(col_s),
    .vga_color(s_col), .vga_de(s_de), .vga_hs(s_hs), .vga_vs(s_vs),
    .vblank(s_vb), .frame_start(s_fs), .frame_count(s_fc)
  );

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vsy, vb, d;
    bit sa;
  } tim_t;

  typedef struct {
    int h, v, fc;
    bit de, hs, vs, vb, fs;
  } exp_t;

  typedef struct {
    int         cyc;
    bit         de;
    logic [7:0] color;
    bit         hs;
    int         h;
    int         v;
  } vec_t;

  tim_t       TD, TS;
  vec_t       tbl [12];
  logic [7:0] hist_d [0:2047];
  logic [7:0] hist_s [0:2047];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Raster position is plain division of elapsed cycles; outputs show the
  // position from COLOR_DELAY+1 cycles earlier.
  function automatic exp_t model(input tim_t p, input int t);
    exp_t e;
    int ht, vt, ft, k, hh, vv;
    ht = p.hv + p.hf + p.hs + p.hb;
    vt = p.vv + p.vf + p.vsy + p.vb;
    ft = ht * vt;
    e.h  = t % ht;
    e.v  = (t / ht) % vt;
    e.vb = (e.v >= p.vv);
    e.fs = (t >= 1) && (((t - 1) % ft) == p.vv * ht);
    e.fc = (t >= p.vv * ht + 1) ? ((t - 1 - p.vv * ht) / ft + 1) : 0;
    k = t - p.d - 1;
    if (k < 0) begin
      e.de = 1'b0;
      e.hs = !p.sa;
      e.vs = !p.sa;
    end else begin
      hh = k % ht;
      vv = (k / ht) % vt;
      e.de = (hh < p.hv) && (vv < p.vv);
      e.hs = (hh >= p.hv + p.hf && hh < p.hv + p.hf + p.hs) ? p.sa : !p.sa;
      e.vs = (vv >= p.vv + p.vf && vv < p.vv + p.vf + p.vsy) ? p.sa : !p.sa;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=0x%0h required=0x%0h", name, t, act, exp);
    end
  endtask

  task automatic cmp_inst(input string nm, input tim_t p, input int t,
                          input logic [31:0] ch, input logic [31:0] cv,
                          input logic [7:0] col, input logic de, input logic hs,
                          input logic vs, input logic vb, input logic fs,
                          input logic [31:0] fc, input logic [7:0] prev_col);
    exp_t e;
    e = model(p, t);
    chk({nm, "_count_h"},     t, ch, e.h);
    chk({nm, "_count_v"},     t, cv, e.v);
    chk({nm, "_vga_de"},      t, 32'(de), 32'(e.de));
    chk({nm, "_vga_color"},   t, 32'(col), e.de ? 32'(prev_col) : 32'd0);
    chk({nm, "_vga_hs"},      t, 32'(hs), 32'(e.hs));
    chk({nm, "_vga_vs"},      t, 32'(vs), 32'(e.vs));
    chk({nm, "_vblank"},      t, 32'(vb), 32'(e.vb));
    chk({nm, "_frame_start"}, t, 32'(fs), 32'(e.fs));
    chk({nm, "_frame_count"}, t, fc, e.fc);
  endtask

  task automatic run_phase(input int n, input bit ramp, input bit use_tbl);
    int ti = 0;
    int low_cnt = 0;
    int first_low = -1;
    for (int t = 0; t < n; t++) begin
      #1;
      cmp_inst("def", TD, t, d_ch, d_cv, d_col, d_de, d_hs, d_vs, d_vb, d_fs, d_fc,
               (t > 0) ? hist_d[t-1] : 8'h00);
      cmp_inst("sml", TS, t, s_ch, s_cv, s_col, s_de, s_hs, s_vs, s_vb, s_fs, s_fc,
               (t > 0) ? hist_s[t-1] : 8'h00);
      if (use_tbl && ti < 12 && tbl[ti].cyc == t) begin
        chk("tbl_de",      t, 32'(d_de),  32'(tbl[ti].de));
        chk("tbl_color",   t, 32'(d_col), 32'(tbl[ti].color));
        chk("tbl_hs",      t, 32'(d_hs),  32'(tbl[ti].hs));
        chk("tbl_count_h", t, d_ch, tbl[ti].h);
        chk("tbl_count_v", t, d_cv, tbl[ti].v);
        ti++;
      end
      if (ramp && t < 10) chk("post_rst_de", t, 32'(d_de), 32'd0);
      if (ramp && t >= 10 && t < 650) chk("align_col", t, 32'(d_col), 32'((t - 10) % 256));
      if (t < 800 && d_hs == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = t;
      end
      col_d = ramp ? ((t >= 9) ? 8'((t - 9) % 800) : 8'h00) : 8'h5A;
      col_s = 8'($urandom);
      hist_d[t] = col_d;
      hist_s[t] = col_s;
      @(negedge clk);
    end
    if (n >= 800) begin
      chk("hs_low_len",   0, low_cnt, 96);
      chk("hs_first_low", 0, first_low, 666);
    end
    if (use_tbl) chk("tbl_all_used", n, ti, 12);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_count_h"},     0, d_ch, 0);
    chk({nm, "_count_v"},     0, d_cv, 0);
    chk({nm, "_vga_de"},      0, 32'(d_de), 0);
    chk({nm, "_vga_color"},   0, 32'(d_col), 0);
    chk({nm, "_vga_hs"},      0, 32'(d_hs), 1);
    chk({nm, "_vga_vs"},      0, 32'(d_vs), 1);
    chk({nm, "_frame_start"}, 0, 32'(d_fs), 0);
    chk({nm, "_frame_count"}, 0, d_fc, 0);
    chk({nm, "_sml_count_h"}, 0, s_ch, 0);
    chk({nm, "_sml_vga_hs"},  0, 32'(s_hs), 0);
    chk({nm, "_sml_vga_vs"},  0, 32'(s_vs), 0);
    chk({nm, "_sml_fc"},      0, s_fc, 0);
  endtask

  initial begin
    TD = '{640, 16, 96, 48, 480, 10, 2, 33, 9, 1'b0};
    TS = '{8, 2, 3, 3, 4, 1, 2, 1, 3, 1'b1};
    //          cyc  de color  hs   h    v
    tbl[0]  = '{0,   0, 8'h00, 1,   0,   0};
    tbl[1]  = '{9,   0, 8'h00, 1,   9,   0};
    tbl[2]  = '{10,  1, 8'h5A, 1,   10,  0};
    tbl[3]  = '{649, 1, 8'h5A, 1,   649, 0};
    tbl[4]  = '{650, 0, 8'h00, 1,   650, 0};
    tbl[5]  = '{665, 0, 8'h00, 1,   665, 0};
    tbl[6]  = '{666, 0, 8'h00, 0,   666, 0};
    tbl[7]  = '{761, 0, 8'h00, 0,   761, 0};
    tbl[8]  = '{762, 0, 8'h00, 1,   762, 0};
    tbl[9]  = '{799, 0, 8'h00, 1,   799, 0};
    tbl[10] = '{800, 0, 8'h00, 1,   0,   1};
    tbl[11] = '{810, 1, 8'h5A, 1,   10,  1};

    rst_n = 1'b0;
    col_d = 8'h00;
    col_s = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_state("rst");

    @(negedge clk);
    rst_n = 1'b1;
    run_phase(1100, 1'b0, 1'b1);

    // Mid-line reset at (300,1) while pixels are being displayed
    #1;
    chk("pre_rst_count_h", 1100, d_ch, 300);
    chk("pre_rst_count_v", 1100, d_cv, 1);
    chk("pre_rst_de",      1100, 32'(d_de), 1);
    chk("pre_rst_sml_fc",  1100, s_fc, 9);
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_phase(1000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
